// File: rtl/norm_round_pipe.sv
// norm_round_pipe: two-stage normaliser and rounder for the MAC back end.
// Stage 1 registers sign/magnitude of the aligned sum. Stage 2 finds the
// leading one, aligns it to the mantissa MSB, rounds (RNE or truncate),
// adjusts the exponent and applies zero/overflow/underflow handling before
// the output register. Both stages advance together under a single enable.
module norm_round_pipe #(
  parameter int SUM_W     = 20,
  parameter int MAN_W     = 11,
  parameter int EXP_IN_W  = 6,
  parameter int EXP_OUT_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_W-1:0]     in_sum,
  input  logic [EXP_IN_W-1:0]  in_exp,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [MAN_W-1:0]     out_man,
  output logic [EXP_OUT_W-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_unf
);

  localparam int P_W   = $clog2(SUM_W + 1);
  localparam int E_W   = EXP_OUT_W + 2;
  localparam int MW1   = MAN_W + 1;
  localparam logic signed [E_W-1:0] E_MAX = E_W'((2 ** (EXP_OUT_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MIN = E_W'(-(2 ** (EXP_OUT_W - 1)));
  localparam logic [SUM_W-1:0] ALL1 = '1;

  // Global advance: the whole pipe moves when the output slot is free or drained.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                       s1_valid;
  logic                       s1_sign;
  logic [SUM_W-1:0]           s1_mag;
  logic signed [EXP_IN_W-1:0] s1_exp;
  logic                       s1_rnd;
  logic                       s1_zero;

  // Stage 1: capture sign, magnitude and side information of the accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_exp   <= '0;
      s1_rnd   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sum[SUM_W-1];
        // Most negative input wraps to 2^(SUM_W-1), which is the correct magnitude.
        s1_mag  <= in_sum[SUM_W-1] ? (~in_sum + SUM_W'(1)) : in_sum;
        s1_exp  <= in_exp;
        s1_rnd  <= rnd_mode;
        s1_zero <= (in_sum == '0);
      end
    end
  end

  // Leading-one position plus one (0 only for a zero magnitude).
  logic [P_W-1:0] lead_p;
  always_comb begin
    lead_p = '0;
    for (int unsigned i = 0; i < SUM_W; i++) begin
      if (s1_mag[i]) lead_p = P_W'(i + 1);
    end
  end

  logic [P_W-1:0]          shift_r;
  logic [SUM_W-1:0]        low_mask;
  logic [SUM_W-1:0]        guard_mask;
  logic [MAN_W-1:0]        man_a;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic [MW1-1:0]          man_sum;
  logic                    carry;
  logic [MAN_W-1:0]        man_r;
  logic signed [E_W-1:0]   exp_e;
  logic                    n_sign;
  logic [MAN_W-1:0]        n_man;
  logic [EXP_OUT_W-1:0]    n_exp;
  logic                    n_zero;
  logic                    n_ovf;
  logic                    n_unf;

  // Stage 2: align, round, compute exponent and apply saturation/flush.
  always_comb begin
    shift_r    = '0;
    low_mask   = '0;
    guard_mask = '0;
    man_a      = '0;
    guard      = 1'b0;
    sticky     = 1'b0;
    if (lead_p <= P_W'(MAN_W)) begin
      // Magnitude already fits in the mantissa, so the left shift cannot lose bits.
      man_a = MAN_W'(s1_mag << (P_W'(MAN_W) - lead_p));
    end else begin
      shift_r    = lead_p - P_W'(MAN_W);
      man_a      = MAN_W'(s1_mag >> shift_r);
      guard_mask = SUM_W'(1) << (shift_r - P_W'(1));
      low_mask   = ~(ALL1 << (shift_r - P_W'(1)));
      guard      = |(s1_mag & guard_mask);
      sticky     = |(s1_mag & low_mask);
    end

    inc     = !s1_rnd && guard && (sticky || man_a[0]);
    man_sum = {1'b0, man_a} + MW1'(inc);
    carry   = man_sum[MAN_W];
    man_r   = carry ? {1'b1, {(MAN_W-1){1'b0}}} : man_sum[MAN_W-1:0];

    exp_e = E_W'(s1_exp) + E_W'(lead_p) - E_W'(MAN_W) + E_W'(carry);

    n_sign = s1_sign;
    n_man  = man_r;
    n_exp  = EXP_OUT_W'(exp_e);
    n_zero = 1'b0;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
    if (s1_zero) begin
      n_sign = 1'b0;
      n_man  = '0;
      n_exp  = '0;
      n_zero = 1'b1;
    end else if (exp_e > E_MAX) begin
      n_man  = '1;
      n_exp  = EXP_OUT_W'(E_MAX);
      n_ovf  = 1'b1;
    end else if (exp_e < E_MIN) begin
      n_sign = 1'b0;
      n_man  = '0;
      n_exp  = '0;
      n_zero = 1'b1;
      n_unf  = 1'b1;
    end
  end

  // Output register: takes stage 2 result on advance; fields hold across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_man   <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= n_sign;
        out_man  <= n_man;
        out_exp  <= n_exp;
        out_zero <= n_zero;
        out_ovf  <= n_ovf;
        out_unf  <= n_unf;
      end
    end
  end

endmodule

// File: tb/tb_norm_round_pipe.sv
// Self-checking bench for norm_round_pipe, built with a 6-bit output exponent
// so that saturation and flush-to-zero are reachable from legal inputs.
module tb_norm_round_pipe;

  localparam int SUM_W     = 20;
  localparam int MAN_W     = 11;
  localparam int EXP_IN_W  = 6;
  localparam int EOW       = 6;
  localparam int EMAX      = (2 ** (EOW - 1)) - 1;
  localparam int EMIN      = -(2 ** (EOW - 1));

  typedef struct packed {
    logic             sign;
    logic [MAN_W-1:0] man;
    logic [EOW-1:0]   exp;
    logic             zero;
    logic             ovf;
    logic             unf;
  } res_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [SUM_W-1:0]    in_sum = '0;
  logic [EXP_IN_W-1:0] in_exp = '0;
  logic                rnd_mode = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                out_sign;
  logic [MAN_W-1:0]    out_man;
  logic [EOW-1:0]      out_exp;
  logic                out_zero;
  logic                out_ovf;
  logic                out_unf;

  int checks = 0;
  int errors = 0;

  res_t exp_q[$];
  res_t got_q[$];
  bit   last_acc = 1'b0;

  norm_round_pipe #(
    .SUM_W     (SUM_W),
    .MAN_W     (MAN_W),
    .EXP_IN_W  (EXP_IN_W),
    .EXP_OUT_W (EOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on the magnitude, rounding by quotient/remainder.
  function automatic res_t model(input logic [SUM_W-1:0] sum, input int e_in, input bit trunc);
    res_t   r;
    longint v, mag, q, rem, half;
    int     p, sh, e;
    r = '0;
    v = longint'($signed(sum));
    mag = (v < 0) ? -v : v;
    if (mag == 0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    while ((mag >> p) != 0) p++;
    if (p <= MAN_W) begin
      q = mag * (longint'(1) << (MAN_W - p));
      e = e_in + p - MAN_W;
    end else begin
      sh   = p - MAN_W;
      q    = mag / (longint'(1) << sh);
      rem  = mag - q * (longint'(1) << sh);
      half = longint'(1) << (sh - 1);
      if (!trunc && (rem > half || (rem == half && (q % 2) == 1))) q++;
      e = e_in + sh;
      if (q == (longint'(1) << MAN_W)) begin
        q = q / 2;
        e++;
      end
    end
    r.sign = (v < 0);
    if (e > EMAX) begin
      r.man = '1;
      r.exp = EOW'(EMAX);
      r.ovf = 1'b1;
    end else if (e < EMIN) begin
      r.sign = 1'b0;
      r.zero = 1'b1;
      r.unf  = 1'b1;
    end else begin
      r.man = MAN_W'(q);
      r.exp = EOW'(e);
    end
    return r;
  endfunction

  // Records accepted inputs (as model results) and delivered outputs mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      last_acc = 1'b0;
    end else begin
      last_acc = in_valid && in_ready;
      if (last_acc) exp_q.push_back(model(in_sum, int'($signed(in_exp)), rnd_mode));
      if (out_valid && out_ready)
        got_q.push_back({out_sign, out_man, out_exp, out_zero, out_ovf, out_unf});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_beat();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       in_sum = '0;
      1:       in_sum = {1'b1, {(SUM_W-1){1'b0}}};
      default: in_sum = SUM_W'(r >> $urandom_range(0, 31));
    endcase
    in_exp   = EXP_IN_W'($urandom);
    rnd_mode = 1'($urandom);
  endtask

  localparam int NV = 16;
  logic [SUM_W-1:0] v_sum [NV] = '{20'h00400, 20'hFFC00, 20'h00801, 20'h00803,
                                   20'h00803, 20'h01803, 20'h00FFF, 20'h00FFF,
                                   20'h80000, 20'h00000, 20'h00800, 20'hFF800,
                                   20'h00400, 20'h00400, 20'h00001, 20'h00001};
  int v_exp  [NV] = '{3, 3, 0, 0, 0, 0, 0, 0, 5, 7, 31, 31, 31, -32, -32, 0};
  int v_rnd  [NV] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int v_sign [NV] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
  int v_man  [NV] = '{'h400, 'h400, 'h400, 'h402, 'h401, 'h601, 'h400, 'h7FF,
                      'h400, 0, 'h7FF, 'h7FF, 'h400, 'h400, 0, 'h400};
  int v_e    [NV] = '{3, 3, 1, 1, 1, 2, 2, 1, 14, 0, 31, 31, 31, -32, 0, -10};
  int v_z    [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  int v_o    [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  int v_u    [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({out_valid, out_sign, out_man, out_exp, out_zero, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b s=%b m=%h e=%h z=%b o=%b u=%b, want all 0",
               out_valid, out_sign, out_man, out_exp, out_zero, out_ovf, out_unf);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    step();
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_sum   = v_sum[i];
      in_exp   = EXP_IN_W'(v_exp[i]);
      rnd_mode = 1'(v_rnd[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_latency: out_valid %b after one edge, want 0", i, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sign !== 1'(v_sign[i]) || out_man !== MAN_W'(v_man[i]) ||
          out_exp !== EOW'(v_e[i]) || out_zero !== 1'(v_z[i]) || out_ovf !== 1'(v_o[i]) ||
          out_unf !== 1'(v_u[i])) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b s=%b m=%h e=%0d z=%b o=%b u=%b want v=1 s=%0d m=%h e=%0d z=%0d o=%0d u=%0d",
                 i, out_valid, out_sign, out_man, $signed(out_exp), out_zero, out_ovf, out_unf,
                 v_sign[i], v_man[i], v_e[i], v_z[i], v_o[i], v_u[i]);
      end
      step();
    end
  endtask

  task automatic test_random();
    int w;
    exp_q.delete();
    got_q.delete();
    for (int b = 0; b < 400; b++) begin
      in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) step();
      rand_beat();
      in_valid = 1'b1;
      w = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        w++;
      end while (!last_acc && w < 64);
      if (!last_acc) begin
        checks++;
        errors++;
        $display("FAIL random_accept_timeout: beat %0d not accepted in %0d cycles", b, w);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_beat_%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t snap;
    logic exp_rdy;
    int   k;
    exp_q.delete();
    got_q.delete();
    snap = '0;
    k = 0;
    rand_beat();
    in_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      exp_rdy = (c < 3 || c > 5);
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      if (c == 3) snap = {out_sign, out_man, out_exp, out_zero, out_ovf, out_unf};
      if (c == 4 || c == 5) begin
        checks++;
        if (out_valid !== 1'b1 ||
            {out_sign, out_man, out_exp, out_zero, out_ovf, out_unf} !== snap) begin
          errors++;
          $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 %h", c, out_valid,
                   {out_sign, out_man, out_exp, out_zero, out_ovf, out_unf}, snap);
        end
      end
      step();
      if (last_acc && k < 5) begin
        k++;
        if (k < 5) rand_beat();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d out / %0d in, want 5 / 5", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat_%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    res_t e;
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rand_beat();
    in_valid = 1'b1;
    step();
    rand_beat();
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_immediate: out_valid %b want 0", out_valid);
    end
    step();
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale_%0d: out_valid %b want 0", i, out_valid);
      end
    end
    rand_beat();
    e = model(in_sum, int'($signed(in_exp)), rnd_mode);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: out_valid %b after one edge, want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 ||
        {out_sign, out_man, out_exp, out_zero, out_ovf, out_unf} !== e) begin
      errors++;
      $display("FAIL midrst_first_beat: got v=%b %h want v=1 %h", out_valid,
               {out_sign, out_man, out_exp, out_zero, out_ovf, out_unf}, e);
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
